// File: rtl/dram_arbiter.sv
// DRAM arbiter for host accesses and CAS-before-RAS refreshes, with one pending host slot.
// Optional macro DRAM_ARBITER_REF_URGENT_EN: when REFPEND is 7, refresh wins over host in IDLE.
module dram_arbiter #(
    parameter int REF_INTERVAL = 91
) (
    input  logic       C7M,
    input  logic       RES,
    input  logic       HREQ,
    input  logic       HBANK,
    output logic       HACK,
    output logic       HOVF,
    output logic       ASel,
    output logic       nRAS,
    output logic       nCAS0,
    output logic       nCAS1,
    output logic [2:0] REFPEND,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        IDLE, HRAS, HCAS1, HCAS2, RCAS, RRAS1, RRAS2, PRE
    } state_t;

    localparam logic [7:0] TIMER_MAX = 8'(REF_INTERVAL - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_timer;
    logic       r_slotValid;
    logic       r_slotBank;
    logic       r_bank;
    logic       w_tick;
    logic       w_urgent;
    logic       w_startHost;
    logic       w_startRef;
    logic       w_drop;
    logic       w_nextBank;
    logic       w_nRas;
    logic       w_nCas0;
    logic       w_nCas1;
    logic       w_aSel;

    assign w_tick     = (r_timer == TIMER_MAX);
    assign w_drop     = HREQ && r_slotValid;
    assign w_nextBank = r_slotValid ? r_slotBank : HBANK;

`ifdef DRAM_ARBITER_REF_URGENT_EN
    assign w_urgent = (REFPEND == 3'd7);
`else
    assign w_urgent = 1'b0;
`endif

    always_comb begin
        w_next      = r_state;
        w_startHost = 1'b0;
        w_startRef  = 1'b0;
        case (r_state)
            IDLE: begin
                if ((HREQ || r_slotValid) && !w_urgent) begin
                    w_next      = HRAS;
                    w_startHost = 1'b1;
                end else if (REFPEND != 3'd0) begin
                    w_next     = RCAS;
                    w_startRef = 1'b1;
                end
            end
            HRAS:    w_next = HCAS1;
            HCAS1:   w_next = HCAS2;
            HCAS2:   w_next = PRE;
            RCAS:    w_next = RRAS1;
            RRAS1:   w_next = RRAS2;
            RRAS2:   w_next = PRE;
            PRE:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Strobes are a pure decode of the state being entered, so the registered pins track the state register.
    always_comb begin
        w_nRas  = 1'b1;
        w_nCas0 = 1'b1;
        w_nCas1 = 1'b1;
        w_aSel  = 1'b0;
        case (w_next)
            HRAS: w_nRas = 1'b0;
            HCAS1, HCAS2: begin
                w_nRas = 1'b0;
                w_aSel = 1'b1;
                if (r_bank) w_nCas1 = 1'b0;
                else        w_nCas0 = 1'b0;
            end
            RCAS: begin
                w_nCas0 = 1'b0;
                w_nCas1 = 1'b0;
            end
            RRAS1, RRAS2: begin
                w_nRas  = 1'b0;
                w_nCas0 = 1'b0;
                w_nCas1 = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge C7M) begin
        if (RES) begin
            r_state     <= IDLE;
            r_timer     <= 8'd0;
            REFPEND     <= 3'd0;
            r_slotValid <= 1'b0;
            r_slotBank  <= 1'b0;
            r_bank      <= 1'b0;
            nRAS        <= 1'b1;
            nCAS0       <= 1'b1;
            nCAS1       <= 1'b1;
            ASel        <= 1'b0;
            HACK        <= 1'b0;
            HOVF        <= 1'b0;
            BUSY        <= 1'b0;
        end else begin
            r_state <= w_next;
            r_timer <= w_tick ? 8'd0 : r_timer + 8'd1;

            // A tick landing on a refresh start cancels out; a tick at 7 is lost.
            if (w_tick && !w_startRef && REFPEND != 3'd7)
                REFPEND <= REFPEND + 3'd1;
            else if (w_startRef && !w_tick)
                REFPEND <= REFPEND - 3'd1;

            if (w_startHost)
                r_bank <= w_nextBank;

            if (w_startHost && r_slotValid) begin
                r_slotValid <= 1'b0;
            end else if (HREQ && !r_slotValid && !w_startHost) begin
                r_slotValid <= 1'b1;
                r_slotBank  <= HBANK;
            end

            nRAS  <= w_nRas;
            nCAS0 <= w_nCas0;
            nCAS1 <= w_nCas1;
            ASel  <= w_aSel;
            HACK  <= (w_next == HCAS2);
            HOVF  <= w_drop;
            BUSY  <= (w_next != IDLE);
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: directed scenarios plus random traffic against a phase-level model.
module tb_dram_arbiter;

    localparam int REF = 8;

    logic       C7M = 1'b0;
    logic       RES = 1'b1;
    logic       HREQ = 1'b0;
    logic       HBANK = 1'b0;
    logic       HACK, HOVF, ASel, nRAS, nCAS0, nCAS1, BUSY;
    logic [2:0] REFPEND;
    logic [9:0] obsVec;

    int vectors = 0;
    int miscompares = 0;

    // Model: an access is a 4-step schedule (phase 1..4, 0 = idle) of kind host or refresh.
    int mPhase = 0;
    bit mHost = 1'b0;
    bit mBank = 1'b0;
    int mTimer = 0;
    int mRefs = 0;
    bit mHovf = 1'b0;
    bit mSlot[$];

    dram_arbiter #(.REF_INTERVAL(REF)) dut (
        .C7M(C7M), .RES(RES), .HREQ(HREQ), .HBANK(HBANK),
        .HACK(HACK), .HOVF(HOVF), .ASel(ASel),
        .nRAS(nRAS), .nCAS0(nCAS0), .nCAS1(nCAS1),
        .REFPEND(REFPEND), .BUSY(BUSY)
    );

    always #5 C7M = ~C7M;

    assign obsVec = {nRAS, nCAS0, nCAS1, ASel, HACK, HOVF, BUSY, REFPEND};

    task automatic modelStep();
        bit tick, idle, goHost, goRef, drop, urgent, slotFull;
        if (RES) begin
            mPhase = 0; mHost = 1'b0; mBank = 1'b0; mTimer = 0; mRefs = 0; mHovf = 1'b0;
            mSlot.delete();
        end else begin
            tick = (mTimer == REF - 1);
            mTimer = tick ? 0 : mTimer + 1;
            idle = (mPhase == 0);
            slotFull = (mSlot.size() != 0);
            urgent = 1'b0;
`ifdef DRAM_ARBITER_REF_URGENT_EN
            urgent = (mRefs == 7);
`endif
            goHost = idle && (HREQ || slotFull) && !urgent;
            goRef = idle && !goHost && (mRefs > 0);
            drop = HREQ && slotFull;
            if (goHost) begin
                if (slotFull) mBank = mSlot.pop_front();
                else          mBank = HBANK;
            end
            if (HREQ && !slotFull && !goHost) mSlot.push_back(HBANK);
            mRefs = mRefs + int'(tick) - int'(goRef);
            if (mRefs > 7) mRefs = 7;
            if (mPhase != 0) mPhase = (mPhase == 4) ? 0 : mPhase + 1;
            else if (goHost || goRef) begin
                mPhase = 1;
                mHost = goHost;
            end
            mHovf = drop;
        end
    endtask

    function automatic logic [9:0] expVec();
        logic ras, c0, c1, asel, hack, busy;
        ras = 1'b1; c0 = 1'b1; c1 = 1'b1; asel = 1'b0;
        if (mHost) begin
            if (mPhase >= 1 && mPhase <= 3) ras = 1'b0;
            if (mPhase == 2 || mPhase == 3) begin
                asel = 1'b1;
                if (mBank) c1 = 1'b0; else c0 = 1'b0;
            end
        end else begin
            if (mPhase == 2 || mPhase == 3) ras = 1'b0;
            if (mPhase >= 1 && mPhase <= 3) begin
                c0 = 1'b0; c1 = 1'b0;
            end
        end
        hack = mHost && (mPhase == 3);
        busy = (mPhase != 0);
        return {ras, c0, c1, asel, hack, mHovf, busy, 3'(mRefs)};
    endfunction

    // Drive one cycle of inputs, advance the model, and land 1 time unit after the edge.
    task automatic applyStimulus(input logic req, input logic bank, input logic rst);
        HREQ = req;
        HBANK = bank;
        RES = rst;
        modelStep();
        @(posedge C7M);
        #1;
    endtask

    task automatic applyReset();
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        RES = 1'b0;
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        RES = 1'b0;
        HREQ = 1'b0;
        vectors++;
        if (obsVec !== 10'b1110000000) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got %b want %b", obsVec, 10'b1110000000);
        end
        vectors++;
        if (obsVec !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL reset_model: got %b want %b", obsVec, expVec());
        end
    endtask

    task automatic test_host_access();
        logic [5:1] eRas  = 5'b11000;
        logic [5:1] eCas1 = 5'b11001;
        logic [5:1] eASel = 5'b00110;
        logic [5:1] eHack = 5'b00100;
        logic [5:1] eBusy = 5'b01111;
        logic [5:0] want;
        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            want = {eRas[k], 1'b1, eCas1[k], eASel[k], eHack[k], eBusy[k]};
            vectors++;
            if ({nRAS, nCAS0, nCAS1, ASel, HACK, BUSY} !== want) begin
                miscompares++;
                $display("[TB] FAIL host_seq n+%0d: got %b want %b", k,
                         {nRAS, nCAS0, nCAS1, ASel, HACK, BUSY}, want);
            end
            vectors++;
            if (obsVec !== expVec()) begin
                miscompares++;
                $display("[TB] FAIL host_model n+%0d: got %b want %b", k, obsVec, expVec());
            end
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_refresh();
        int rcasCount = 0;
        int pendOne = 0;
        int pendHigh = 0;
        applyReset();
        for (int c = 1; c <= 40; c++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            if (nRAS === 1'b1 && nCAS0 === 1'b0 && nCAS1 === 1'b0) rcasCount++;
            if (REFPEND === 3'd1) pendOne++;
            if (REFPEND > 3'd1) pendHigh++;
            vectors++;
            if (obsVec !== expVec()) begin
                miscompares++;
                $display("[TB] FAIL refresh_model c%0d: got %b want %b", c, obsVec, expVec());
            end
        end
        vectors++;
        if (rcasCount !== 4 || pendOne !== 5 || pendHigh !== 0) begin
            miscompares++;
            $display("[TB] FAIL refresh_counts: got rcas=%0d pend1=%0d pendHigh=%0d want 4 5 0",
                     rcasCount, pendOne, pendHigh);
        end
    endtask

    task automatic test_overflow();
        logic b;
        b = 1'($urandom_range(0, 1));
        applyReset();
        for (int c = 1; c <= 10; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            vectors++;
            if (obsVec !== expVec()) begin
                miscompares++;
                $display("[TB] FAIL ovf_model c%0d: got %b want %b", c, obsVec, expVec());
            end
        end
        vectors++;
        if ({nRAS, nCAS0, nCAS1} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL ovf_rras1: got %b want 000", {nRAS, nCAS0, nCAS1});
        end
        applyStimulus(1'b1, b, 1'b0);
        vectors++;
        if (HOVF !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ovf_first_kept: got HOVF=%b want 0", HOVF);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, ~b, 1'b0);
        vectors++;
        if (HOVF !== 1'b1 || BUSY !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ovf_drop: got HOVF=%b BUSY=%b want 1 0", HOVF, BUSY);
        end
        for (int c = 14; c <= 16; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            vectors++;
            if (obsVec !== expVec()) begin
                miscompares++;
                $display("[TB] FAIL ovf_model c%0d: got %b want %b", c, obsVec, expVec());
            end
        end
        vectors++;
        if (HACK !== 1'b1 || (b ? nCAS1 : nCAS0) !== 1'b0 || (b ? nCAS0 : nCAS1) !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ovf_served: got HACK=%b nCAS0=%b nCAS1=%b want HACK=1 bank=%0d low",
                     HACK, nCAS0, nCAS1, b);
        end
    endtask

    task automatic test_saturation();
        applyReset();
        for (int i = 0; i < 120; i++) begin
            applyStimulus((i % 4) == 0, 1'($urandom_range(0, 1)), 1'b0);
            vectors++;
            if (obsVec !== expVec()) begin
                miscompares++;
                $display("[TB] FAIL sat_model i%0d: got %b want %b", i, obsVec, expVec());
            end
        end
`ifndef DRAM_ARBITER_REF_URGENT_EN
        vectors++;
        if (REFPEND !== 3'd7) begin
            miscompares++;
            $display("[TB] FAIL sat_refpend: got %0d want 7", REFPEND);
        end
`endif
    endtask

    task automatic test_reset_mid();
        applyReset();
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        vectors++;
        if (ASel !== 1'b1 || nRAS !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_hcas1: got ASel=%b nRAS=%b want 1 0", ASel, nRAS);
        end
        applyStimulus(1'b1, 1'b1, 1'b1);
        vectors++;
        if ({nRAS, nCAS0, nCAS1, ASel, HACK, BUSY, REFPEND} !== 9'b111000000) begin
            miscompares++;
            $display("[TB] FAIL mid_reset: got %b want 111000000",
                     {nRAS, nCAS0, nCAS1, ASel, HACK, BUSY, REFPEND});
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        vectors++;
        if (BUSY !== 1'b0 || nRAS !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_hreq_ignored: got BUSY=%b nRAS=%b want 0 1", BUSY, nRAS);
        end
    endtask

    task automatic test_random();
        logic req, bank, rst;
        applyReset();
        for (int i = 0; i < 400; i++) begin
            req = ($urandom_range(0, 2) == 0);
            bank = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 49) == 0);
            applyStimulus(req, bank, rst);
            vectors++;
            if (obsVec !== expVec()) begin
                miscompares++;
                $display("[TB] FAIL random_model i%0d: got %b want %b", i, obsVec, expVec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_host_access();
        test_refresh();
        test_overflow();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 SHALL have parameter REF_INTERVAL, default 91, meaning C7M cycles between refresh ticks (legal 8..255).
REQ-002 SHALL have port C7M  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RES  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port HREQ  in  1  host access request, one-cycle pulse.
REQ-005 SHALL have port HBANK  in  1  DRAM bank select for the request (0: CAS0, 1: CAS1), sampled with HREQ.
REQ-006 SHALL have port HACK  out  1  one-cycle pulse in the last CAS cycle of a host access.
REQ-007 SHALL have port HOVF  out  1  one-cycle pulse when a host request is dropped.
REQ-008 SHALL have port ASel  out  1  DRAM address mux select (0 row, 1 column).
REQ-009 SHALL have ports nRAS, nCAS0, nCAS1  out  1 each  DRAM strobes, active-low.
REQ-010 SHALL have port REFPEND  out  3  count of owed refreshes.
REQ-011 SHALL have port BUSY  out  1  high whenever state is not IDLE.

Function
REQ-012 SHALL register all outputs; strobes and ASel are decoded from the current state only.
REQ-013 SHALL run a timer 0..REF_INTERVAL-1 that wraps to 0; a tick occurs in the cycle the timer equals REF_INTERVAL-1.
REQ-014 SHALL keep REFPEND saturating at 7: tick increments; refresh start decrements; tick and start in the same cycle leave it unchanged; tick at 7 is lost.
REQ-015 SHALL hold one pending host slot (request flag plus bank); HREQ while the slot is full drops the new request and pulses HOVF in the next cycle.
REQ-016 SHALL use states IDLE, HRAS, HCAS1, HCAS2, RCAS, RRAS1, RRAS2 and PRE.
REQ-017 SHALL, in IDLE, start a host access (to HRAS) when HREQ or the slot is set, else start a refresh (to RCAS) when REFPEND>0, else remain in IDLE.
REQ-018 SHALL sequence a host access as HRAS (nRAS=0, ASel=0), then HCAS1 and HCAS2 (nRAS=0, ASel=1, selected nCASn=0), then PRE, then IDLE.
REQ-019 SHALL give a host access latency of 3 cycles: HREQ in cycle n, HRAS in n+1, HACK in n+3, HCAS2 in n+3.
REQ-020 SHALL sequence a refresh (CAS-before-RAS) as RCAS (nCAS0=nCAS1=0, nRAS=1), then RRAS1 and RRAS2 (all strobes low), then PRE, then IDLE.
REQ-021 SHALL decrement REFPEND on entry to RCAS.
REQ-022 SHALL drive all strobes high and ASel=0 in PRE and IDLE.
REQ-023 SHALL set the slot on HREQ when not accepted directly from IDLE, and clear it on entry to HRAS.
REQ-024 SHALL NOT let a request arriving mid-sequence shorten or abort the current sequence.

Reset
REQ-025 SHALL, on RES sampled high, set state=IDLE, timer=0, REFPEND=0, slot clear, nRAS=nCAS0=nCAS1=1, ASel=0, HACK=0, HOVF=0, BUSY=0.
REQ-026 SHALL, on reset mid-access, abort with no HACK and no strobe glitch beyond the reset cycle, and ignore HREQ during the reset cycle.

Configuration
REQ-027 SHALL provide macro DRAM_ARBITER_REF_URGENT_EN: when defined, IDLE selects refresh over host if REFPEND==7; when undefined, host always wins, as in REQ-017.

Verification
REQ-028 SHALL cover: HREQ=1, HBANK=1 at idle, cycle 10 -> nRAS low cycles 11-13, ASel=1 cycles 12-13, nCAS1 low cycles 12-13, nCAS0 high, HACK cycle 13, IDLE cycle 15.
REQ-029 SHALL cover: REF_INTERVAL=8, no host traffic -> REFPEND pulses 0->1, RCAS entered one cycle after each tick, 4-cycle CBR pattern, REFPEND returns to 0.
REQ-030 SHALL cover: HREQ during refresh RRAS1, then second HREQ two cycles later -> first served after PRE with HACK, second dropped with HOVF pulse.
REQ-031 SHALL cover: host HREQ every 4 cycles until REFPEND=7 -> with macro, refresh precedes next host access; without, host wins and REFPEND holds 7 with ticks lost.
REQ-032 SHALL cover: RES asserted in HCAS1 -> next cycle all strobes high, ASel=0, no HACK, REFPEND=0.
